cache_stats_counter: RTL and testbench

Synthesizable, parametrised statistics unit for the L2 cache model. It replaces bench-side counting of hit/miss/read/write pulses with per-channel saturating counters, an atomic snapshot and a serial hit-ratio divider. It sits beside the L2 cache and takes its one-cycle event strobes; the bench or a debug port reads the results.

---
 rtl/cache_stats_pkg.sv | 15 +
 rtl/stats_ratio_div.sv | 97 +++++++++
 rtl/cache_stats_counter.sv | 107 ++++++++++
 tb/tb_cache_stats_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared constants and types for the L2 cache statistics unit.
package cache_stats_pkg;

    localparam int unsigned EV_HIT   = 0;
    localparam int unsigned EV_MISS  = 1;
    localparam int unsigned EV_READ  = 2;
    localparam int unsigned EV_WRITE = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/stats_ratio_div.sv
// Serial restoring divider: quot = num * 2^(Q_W-1) / den, one quotient bit per cycle, MSB first.
module stats_ratio_div
    import cache_stats_pkg::*;
#(
    parameter int unsigned OP_W = 33,
    parameter int unsigned Q_W  = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] num,
    input  logic [OP_W-1:0] den,
    output logic [Q_W-1:0]  quot,
    output logic            div0,
    output logic            busy,
    output logic            done
);

    localparam int unsigned REM_W  = OP_W + 1;
    localparam int unsigned STEP_W = $clog2(Q_W);

    state_e              state, state_nx;
    logic [REM_W-1:0]    rem, rem_nx;
    logic [OP_W-1:0]     den_q, den_nx;
    logic [Q_W-1:0]      acc, acc_nx, quot_nx;
    logic                div0_nx;
    logic [STEP_W-1:0]   step, step_nx;
    logic                ge;
    logic [REM_W-1:0]    diff;

    // Next-state, datapath step and result capture
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        den_nx   = den_q;
        acc_nx   = acc;
        quot_nx  = quot;
        div0_nx  = div0;
        step_nx  = step;
        ge       = (rem >= {1'b0, den_q});
        diff     = ge ? (rem - {1'b0, den_q}) : rem;
        case (state)
            IDLE: begin
                if (start) begin
                    if (den == '0) begin
                        state_nx = DONE;
                        quot_nx  = '0;
                        div0_nx  = 1'b1;
                    end else begin
                        state_nx = DIV;
                        rem_nx   = {1'b0, num};
                        den_nx   = den;
                        acc_nx   = '0;
                        step_nx  = '0;
                    end
                end
            end
            DIV: begin
                acc_nx  = {acc[Q_W-2:0], ge};
                rem_nx  = {diff[REM_W-2:0], 1'b0};
                step_nx = step + 1'b1;
                if (step == STEP_W'(Q_W - 1)) begin
                    state_nx = DONE;
                    quot_nx  = acc_nx;
                    div0_nx  = 1'b0;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            den_q <= '0;
            acc   <= '0;
            step  <= '0;
            quot  <= '0;
            div0  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            den_q <= den_nx;
            acc   <= acc_nx;
            step  <= step_nx;
            quot  <= quot_nx;
            div0  <= div0_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
        end
    end

endmodule

// File: rtl/cache_stats_counter.sv
// Per-channel saturating event counters with atomic snapshot and serial hit-ratio divider.
module cache_stats_counter
    import cache_stats_pkg::*;
#(
    parameter int unsigned NUM_EVENTS    = 4,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned RATIO_F       = 8,
    parameter int unsigned CLEAR_ON_SNAP = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_EVENTS-1:0]         event_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic                          snap_i,
    output logic                          snap_busy_o,
    output logic                          snap_done_o,
    input  logic [$clog2(NUM_EVENTS)-1:0] rd_idx_i,
    output logic [CNT_W-1:0]              rd_data_o,
    output logic [NUM_EVENTS-1:0]         sat_o,
    output logic [RATIO_F:0]              ratio_o,
    output logic                          div0_o
);

    localparam int unsigned IDX_W = $clog2(NUM_EVENTS);
    localparam int unsigned OP_W  = CNT_W + 1;
    localparam int unsigned Q_W   = RATIO_F + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]      cnt    [NUM_EVENTS];
    logic [CNT_W-1:0]      cnt_nx [NUM_EVENTS];
    logic [CNT_W-1:0]      shadow [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] sat, sat_nx;
    logic                  start;
    logic [OP_W-1:0]       div_num, div_den;

    // Busy covers DIV and DONE, so requests arriving then are dropped
    assign start = snap_i & ~snap_busy_o;

    // Live counter update: clear beats snapshot reload beats counting
    always_comb begin
        cnt_nx = cnt;
        sat_nx = sat;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (clear_i) begin
                cnt_nx[k] = '0;
                sat_nx[k] = 1'b0;
            end else if (start && (CLEAR_ON_SNAP != 0)) begin
                cnt_nx[k] = CNT_W'(event_i[k] & enable_i);
                sat_nx[k] = 1'b0;
            end else if (enable_i && event_i[k]) begin
                if (cnt[k] == CNT_MAX) begin
                    sat_nx[k] = 1'b1;
                end else begin
                    cnt_nx[k] = cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                cnt[k]    <= '0;
                shadow[k] <= '0;
            end
            sat   <= '0;
            sat_o <= '0;
        end else begin
            cnt <= cnt_nx;
            sat <= sat_nx;
            if (start) begin
                shadow <= cnt;
                sat_o  <= sat;
            end
        end
    end

    // Operands taken from the pre-event live values, identical to what the shadows capture
    assign div_num = OP_W'(cnt[EV_HIT]);
    assign div_den = OP_W'(cnt[EV_HIT]) + OP_W'(cnt[EV_MISS]);

    stats_ratio_div #(
        .OP_W (OP_W),
        .Q_W  (Q_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .num   (div_num),
        .den   (div_den),
        .quot  (ratio_o),
        .div0  (div0_o),
        .busy  (snap_busy_o),
        .done  (snap_done_o)
    );

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (rd_idx_i == IDX_W'(k)) begin
                rd_data_o = shadow[k];
            end
        end
    end

endmodule

// File: tb/tb_cache_stats_counter.sv
// Directed bench for cache_stats_counter: instance a (CNT_W=4) and instance b (CLEAR_ON_SNAP=1).
module tb_cache_stats_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] a_event, b_event;
    logic       a_en, b_en, a_clr, b_clr, a_snap, b_snap;
    logic [1:0] a_idx, b_idx;
    logic       a_busy, b_busy, a_done, b_done, a_div0, b_div0;
    logic [3:0] a_rd, a_sat, b_sat;
    logic [31:0] b_rd;
    logic [8:0] a_ratio, b_ratio;

    cache_stats_counter #(.NUM_EVENTS(4), .CNT_W(4), .RATIO_F(8), .CLEAR_ON_SNAP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .event_i(a_event), .enable_i(a_en), .clear_i(a_clr),
        .snap_i(a_snap), .snap_busy_o(a_busy), .snap_done_o(a_done), .rd_idx_i(a_idx),
        .rd_data_o(a_rd), .sat_o(a_sat), .ratio_o(a_ratio), .div0_o(a_div0));

    cache_stats_counter #(.NUM_EVENTS(4), .CNT_W(32), .RATIO_F(8), .CLEAR_ON_SNAP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .event_i(b_event), .enable_i(b_en), .clear_i(b_clr),
        .snap_i(b_snap), .snap_busy_o(b_busy), .snap_done_o(b_done), .rd_idx_i(b_idx),
        .rd_data_o(b_rd), .sat_o(b_sat), .ratio_o(b_ratio), .div0_o(b_div0));

    typedef struct {
        logic [8:0] ratio;
        logic       div0;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input bit inst);
        return inst ? b_done : a_done;
    endfunction

    function automatic logic busy_of(input bit inst);
        return inst ? b_busy : a_busy;
    endfunction

    task automatic set_snap(input bit inst, input logic v);
        if (inst) b_snap = v; else a_snap = v;
    endtask

    task automatic ev(input bit inst, input logic [3:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            if (inst) b_event = pat; else a_event = pat;
            tick();
        end
        a_event = '0;
        b_event = '0;
    endtask

    task automatic clear_live(input bit inst);
        if (inst) b_clr = 1'b1; else a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        b_clr = 1'b0;
    endtask

    task automatic rd_check(input bit inst, input logic [1:0] idx, input logic [63:0] expv,
                            input string tag);
        if (inst) b_idx = idx; else a_idx = idx;
        #1;
        check(tag, inst ? 64'(b_rd) : 64'(a_rd), expv);
    endtask

    task automatic count_done(input bit inst, input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done_of(inst)) pulses++;
        end
    endtask

    // Issue one snapshot; the expected result rides the scoreboard until the done pulse
    task automatic do_snap(input bit inst, input logic [8:0] er, input bit ed, input int elat,
                           input bit with_clear, input bit with_hit, input int dup_at,
                           input string tag);
        exp_t e;
        int   lat;
        e.ratio = er;
        e.div0  = ed;
        e.lat   = elat;
        sb.push_back(e);
        set_snap(inst, 1'b1);
        if (inst) begin
            b_clr   = with_clear;
            b_event = with_hit ? 4'b0001 : 4'b0000;
        end else begin
            a_clr   = with_clear;
            a_event = with_hit ? 4'b0001 : 4'b0000;
        end
        tick();
        set_snap(inst, 1'b0);
        a_clr = 1'b0; b_clr = 1'b0; a_event = '0; b_event = '0;
        lat = 1;
        check({tag, "_busy"}, 64'(busy_of(inst)), 64'd1);
        while (!done_of(inst) && lat < 40) begin
            if (lat == dup_at) set_snap(inst, 1'b1);
            tick();
            set_snap(inst, 1'b0);
            lat++;
        end
        check({tag, "_done_seen"}, 64'(done_of(inst)), 64'd1);
        e = sb.pop_front();
        check({tag, "_ratio"}, inst ? 64'(b_ratio) : 64'(a_ratio), 64'(e.ratio));
        check({tag, "_div0"}, inst ? 64'(b_div0) : 64'(a_div0), 64'(e.div0));
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        tick();
        check({tag, "_done_pulse_len"}, 64'(done_of(inst)), 64'd0);
        check({tag, "_busy_release"}, 64'(busy_of(inst)), 64'd0);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        a_event = '0; b_event = '0; a_en = 1'b0; b_en = 1'b0;
        a_clr = 1'b0; b_clr = 1'b0; a_snap = 1'b0; b_snap = 1'b0;
        a_idx = '0; b_idx = '0;
        tick();
        tick();
        check("rst_ratio", 64'(a_ratio), 64'd0);
        check("rst_div0", 64'(a_div0), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_sat", 64'(a_sat), 64'd0);
        rd_check(1'b0, 2'd0, 64'd0, "rst_rd0");
        rst_n = 1'b1;
        tick();

        // 3 hits + 3 reads, 1 miss + 1 write, one hit while disabled
        a_en = 1'b1;
        ev(1'b0, 4'b0101, 3);
        ev(1'b0, 4'b1010, 1);
        a_en = 1'b0;
        ev(1'b0, 4'b0001, 1);
        a_en = 1'b1;
        do_snap(1'b0, 9'h0C0, 1'b0, 10, 1'b0, 1'b0, -1, "ratio_3of4");
        rd_check(1'b0, 2'd0, 64'd3, "ratio_3of4_hit");
        rd_check(1'b0, 2'd1, 64'd1, "ratio_3of4_miss");
        rd_check(1'b0, 2'd2, 64'd3, "ratio_3of4_read");
        rd_check(1'b0, 2'd3, 64'd1, "ratio_3of4_write");

        // Saturation at 4 bits, then clear
        clear_live(1'b0);
        ev(1'b0, 4'b0001, 17);
        do_snap(1'b0, 9'h100, 1'b0, 10, 1'b0, 1'b0, -1, "sat_snap");
        rd_check(1'b0, 2'd0, 64'd15, "sat_hold");
        check("sat_flag", 64'(a_sat), 64'h1);
        clear_live(1'b0);
        do_snap(1'b0, 9'h000, 1'b1, 1, 1'b0, 1'b0, -1, "div0_snap");
        rd_check(1'b0, 2'd0, 64'd0, "cleared_hit");
        check("cleared_sat", 64'(a_sat), 64'h0);
        ev(1'b0, 4'b0001, 5);
        do_snap(1'b0, 9'h100, 1'b0, 10, 1'b0, 1'b0, -1, "all_hits");

        // clear, snap and hit in the same cycle on a live hit count of 7
        clear_live(1'b0);
        ev(1'b0, 4'b0001, 7);
        do_snap(1'b0, 9'h100, 1'b0, 10, 1'b1, 1'b1, -1, "clr_snap_same");
        rd_check(1'b0, 2'd0, 64'd7, "clr_snap_shadow");
        do_snap(1'b0, 9'h000, 1'b1, 1, 1'b0, 1'b0, -1, "clr_wins");
        rd_check(1'b0, 2'd0, 64'd0, "clr_wins_hit");

        // 1 of 4, then abort a 2 of 4 division with reset
        ev(1'b0, 4'b0001, 1);
        ev(1'b0, 4'b0010, 3);
        do_snap(1'b0, 9'h040, 1'b0, 10, 1'b0, 1'b0, -1, "ratio_1of4");
        clear_live(1'b0);
        ev(1'b0, 4'b0001, 2);
        ev(1'b0, 4'b0010, 2);
        a_snap = 1'b1;
        tick();
        a_snap = 1'b0;
        tick();
        tick();
        tick();
        check("abort_pre_busy", 64'(a_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(a_busy), 64'd0);
        check("abort_done", 64'(a_done), 64'd0);
        check("abort_ratio", 64'(a_ratio), 64'd0);
        check("abort_div0", 64'(a_div0), 64'd0);
        rd_check(1'b0, 2'd0, 64'd0, "abort_shadow");
        tick();
        rst_n = 1'b1;
        count_done(1'b0, 15, pulses);
        check("abort_no_done", 64'(pulses), 64'd0);
        ev(1'b0, 4'b0001, 1);
        ev(1'b0, 4'b0010, 1);
        do_snap(1'b0, 9'h080, 1'b0, 10, 1'b0, 1'b0, -1, "post_abort");
        rd_check(1'b0, 2'd0, 64'd1, "post_abort_hit");

        // Interval mode: hit in the snap cycle goes to the next interval
        b_en = 1'b1;
        ev(1'b1, 4'b0001, 4);
        do_snap(1'b1, 9'h100, 1'b0, 10, 1'b0, 1'b1, 3, "interval1");
        rd_check(1'b1, 2'd0, 64'd4, "interval1_hit");
        count_done(1'b1, 15, pulses);
        check("busy_snap_dropped", 64'(pulses), 64'd0);
        ev(1'b1, 4'b0001, 2);
        do_snap(1'b1, 9'h100, 1'b0, 10, 1'b0, 1'b0, -1, "interval2");
        rd_check(1'b1, 2'd0, 64'd3, "interval2_hit");
        rd_check(1'b1, 2'd1, 64'd0, "interval2_miss");
        check("interval2_sat", 64'(b_sat), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
